// File: rtl/alu_pkg.sv
// Shared opcode encodings and overflow helpers for the execute-stage ALU.
// The instruction decoder uses the same constants to drive ALUop.
package alu_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLL   = 5'd6;
  localparam logic [4:0] ALU_SRL   = 5'd7;
  localparam logic [4:0] ALU_SRA   = 5'd8;
  localparam logic [4:0] ALU_SLLV  = 5'd9;
  localparam logic [4:0] ALU_SRLV  = 5'd10;
  localparam logic [4:0] ALU_SRAV  = 5'd11;
  localparam logic [4:0] ALU_SLT   = 5'd12;
  localparam logic [4:0] ALU_SLTU  = 5'd13;
  localparam logic [4:0] ALU_LUI   = 5'd14;
  localparam logic [4:0] ALU_PASSB = 5'd15;
  localparam logic [4:0] ALU_CLZ   = 5'd16;

  // Signed overflow of a + b: operands agree in sign, sum does not.
  function automatic logic add_overflow(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] sum);
    return (a[31] == b[31]) && (sum[31] != a[31]);
  endfunction

  // Signed overflow of a - b: operands differ in sign, difference takes b's sign.
  function automatic logic sub_overflow(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] diff);
    return (a[31] != b[31]) && (diff[31] != a[31]);
  endfunction

  function automatic logic is_var_shift(input logic [4:0] op);
    return (op == ALU_SLLV) || (op == ALU_SRLV) || (op == ALU_SRAV);
  endfunction

endpackage

// File: rtl/alu_clz.sv
// Combinational 32-bit leading-zero counter; result range 0..32.
// Binary search narrows the window by half at each level.
module alu_clz
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  output logic [5:0]  o_count
);

  logic        w_z4, w_z3, w_z2, w_z1, w_z0;
  logic [15:0] w_h;
  logic [7:0]  w_b;
  logic [3:0]  w_n;
  logic [1:0]  w_p;
  logic        w_all_zero;

  assign w_all_zero = (i_a == 32'd0);

  assign w_z4 = (i_a[31:16] == 16'd0);
  assign w_h  = w_z4 ? i_a[15:0] : i_a[31:16];
  assign w_z3 = (w_h[15:8] == 8'd0);
  assign w_b  = w_z3 ? w_h[7:0] : w_h[15:8];
  assign w_z2 = (w_b[7:4] == 4'd0);
  assign w_n  = w_z2 ? w_b[3:0] : w_b[7:4];
  assign w_z1 = (w_n[3:2] == 2'd0);
  assign w_p  = w_z1 ? w_n[1:0] : w_n[3:2];
  assign w_z0 = ~w_p[1];

  assign o_count = w_all_zero ? 6'd32 : {1'b0, w_z4, w_z3, w_z2, w_z1, w_z0};

endmodule

// File: rtl/alu_e.sv
// Execute-stage ALU: one combinational case on ALUop feeding a result and
// signed-overflow register. Overflow is reported but the result still wraps.
module alu_e
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [4:0]  Shift,
  input  logic [4:0]  ALUop,
  output logic [31:0] ALUresult,
  output logic        Overflow
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_amt;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [5:0]  w_clz;
  logic [31:0] w_result;
  logic        w_overflow;
  logic [31:0] r_result;
  logic        r_overflow;

  assign w_sum  = SrcA + SrcB;
  assign w_diff = SrcA - SrcB;

  // Variable shifts take only the low five bits of A.
  assign w_amt = is_var_shift(ALUop) ? SrcA[4:0] : Shift;
  assign w_sll = SrcB << w_amt;
  assign w_srl = SrcB >> w_amt;
  assign w_sra = $unsigned($signed(SrcB) >>> w_amt);

  alu_clz u_clz (
    .i_a     (SrcA),
    .o_count (w_clz)
  );

  // Next-state result and overflow selected by operation code.
  always_comb begin
    w_result   = 32'd0;
    w_overflow = 1'b0;
    case (ALUop)
      ALU_ADD: begin
        w_result   = w_sum;
        w_overflow = add_overflow(SrcA, SrcB, w_sum);
      end
      ALU_SUB: begin
        w_result   = w_diff;
        w_overflow = sub_overflow(SrcA, SrcB, w_diff);
      end
      ALU_AND:   w_result = SrcA & SrcB;
      ALU_OR:    w_result = SrcA | SrcB;
      ALU_XOR:   w_result = SrcA ^ SrcB;
      ALU_NOR:   w_result = ~(SrcA | SrcB);
      ALU_SLL:   w_result = w_sll;
      ALU_SRL:   w_result = w_srl;
      ALU_SRA:   w_result = w_sra;
      ALU_SLLV:  w_result = w_sll;
      ALU_SRLV:  w_result = w_srl;
      ALU_SRAV:  w_result = w_sra;
      ALU_SLT:   w_result = {31'd0, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU:  w_result = {31'd0, (SrcA < SrcB)};
      ALU_LUI:   w_result = {SrcB[15:0], 16'd0};
      ALU_PASSB: w_result = SrcB;
      ALU_CLZ:   w_result = {26'd0, w_clz};
      default: begin
        w_result   = 32'd0;
        w_overflow = 1'b0;
      end
    endcase
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result   <= 32'd0;
      r_overflow <= 1'b0;
    end else begin
      r_result   <= w_result;
      r_overflow <= w_overflow;
    end
  end

  assign ALUresult = r_result;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_alu_e.sv
// Directed self-checking bench for alu_e; expected values are hand-computed.
module tb_alu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  Shift;
  logic [4:0]  ALUop;
  logic [31:0] ALUresult;
  logic        Overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_e dut (
    .clk       (clk),
    .reset     (reset),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Shift     (Shift),
    .ALUop     (ALUop),
    .ALUresult (ALUresult),
    .Overflow  (Overflow)
  );

  // Apply inputs at the falling edge, then sample 1 unit after the rising edge.
  task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] op);
    @(negedge clk);
    reset = rst;
    SrcA  = a;
    SrcB  = b;
    Shift = sh;
    ALUop = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 5'd0);
      checks++;
      if (ALUresult !== 32'd0 || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset edge %0d: got result=%h ovf=%b, want 00000000/0", i, ALUresult, Overflow);
      end
    end
  endtask

  task automatic test_clz();
    logic [31:0] va [5] = '{32'd64, 32'd0, 32'h8000_0000, 32'd1, 32'h0000_FFFF};
    logic [31:0] ve [5] = '{32'd25, 32'd32, 32'd0, 32'd31, 32'd16};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, va[i], 32'd0, 5'd0, 5'd16);
      checks++;
      if (ALUresult !== ve[i] || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL clz A=%h: got %0d ovf=%b, want %0d/0", va[i], ALUresult, Overflow, ve[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] va [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'd5, 32'd0};
    logic [31:0] vb [6] = '{32'd1, 32'd1, 32'd3, 32'h8000_0000, 32'd3, 32'd1};
    logic [4:0]  vo [6] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [31:0] ve [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd8, 32'd0, 32'd2, 32'hFFFF_FFFF};
    logic        vv [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, va[i], vb[i], 5'd0, vo[i]);
      checks++;
      if (ALUresult !== ve[i] || Overflow !== vv[i]) begin
        errors++;
        $display("FAIL addsub #%0d: got %h ovf=%b, want %h/%b", i, ALUresult, Overflow, ve[i], vv[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [31:0] va [8] = '{32'd0, 32'h24, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFE4, 32'h21, 32'd0};
    logic [31:0] vb [8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'd1,
                            32'h8000_0000, 32'h8000_0000, 32'd3, 32'h8000_0001};
    logic [4:0]  vs [8] = '{5'd4, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd7, 5'd0};
    logic [4:0]  vo [8] = '{5'd8, 5'd10, 5'd6, 5'd6, 5'd7, 5'd11, 5'd9, 5'd8};
    logic [31:0] ve [8] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0001, 32'h8000_0000,
                            32'h0800_0000, 32'hF800_0000, 32'd6, 32'h8000_0001};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, va[i], vb[i], vs[i], vo[i]);
      checks++;
      if (ALUresult !== ve[i] || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL shift #%0d op=%0d: got %h ovf=%b, want %h/0", i, vo[i], ALUresult, Overflow, ve[i]);
      end
    end
  endtask

  task automatic test_logic_cmp();
    logic [31:0] va [11] = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0,
                             32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vb [11] = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                             32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234,
                             32'hDEAD_BEEF, 32'd1};
    logic [4:0]  vo [11] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd12, 5'd13, 5'd12, 5'd13, 5'd14,
                             5'd15, 5'd20};
    logic [31:0] ve [11] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000,
                             32'd1, 32'd0, 32'd0, 32'd1, 32'h1234_0000,
                             32'hDEAD_BEEF, 32'd0};
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, va[i], vb[i], 5'd3, vo[i]);
      checks++;
      if (ALUresult !== ve[i] || Overflow !== 1'b0) begin
        errors++;
        $display("FAIL logic/cmp #%0d op=%0d: got %h ovf=%b, want %h/0", i, vo[i], ALUresult, Overflow, ve[i]);
      end
    end
    drive(1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd31);
    checks++;
    if (ALUresult !== 32'd0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reserved op31: got %h ovf=%b, want 00000000/0", ALUresult, Overflow);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 32'd10, 32'd20, 5'd0, 5'd0);
    checks++;
    if (ALUresult !== 32'd30) begin
      errors++;
      $display("FAIL b2b add: got %h, want 0000001e", ALUresult);
    end
    // Inputs changed between edges must not disturb the held output.
    SrcA  = 32'h7FFF_FFFF;
    SrcB  = 32'd1;
    ALUop = 5'd0;
    #2;
    checks++;
    if (ALUresult !== 32'd30 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b hold: got %h ovf=%b, want 0000001e/0", ALUresult, Overflow);
    end
    drive(1'b0, 32'd10, 32'd20, 5'd0, 5'd1);
    checks++;
    if (ALUresult !== 32'hFFFF_FFF6 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b sub: got %h ovf=%b, want fffffff6/0", ALUresult, Overflow);
    end
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    checks++;
    if (ALUresult !== 32'd0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL midstream reset: got %h ovf=%b, want 00000000/0", ALUresult, Overflow);
    end
    drive(1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    checks++;
    if (ALUresult !== 32'h8000_0000 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL after reset: got %h ovf=%b, want 80000000/1", ALUresult, Overflow);
    end
    drive(1'b0, 32'd0, 32'h0000_00AB, 5'd0, 5'd15);
    checks++;
    if (ALUresult !== 32'h0000_00AB || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b passb: got %h ovf=%b, want 000000ab/0", ALUresult, Overflow);
    end
  endtask

  initial begin
    reset = 1'b1;
    SrcA  = 32'hFFFF_FFFF;
    SrcB  = 32'd0;
    Shift = 5'd0;
    ALUop = 5'd0;
    test_reset();
    test_clz();
    test_add_sub();
    test_shifts();
    test_logic_cmp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
